// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters.
// Picks a pending requester, latches its byte, pulses tx_start and req_ack,
// then times the whole frame (the transmitter has no done flag) before
// re-arbitrating. Round-robin by default; define UART_ARB_FIXED_PRIO_EN for
// fixed lowest-index-wins priority (round-robin pointer removed).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 20,
  parameter int GUARD_CLKS   = 2,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  // Ten UART bits of CLKS_PER_BIT+1 clocks each, plus an idle margin.
  localparam int FRAME_CLKS = 10 * (CLKS_PER_BIT + 1) + GUARD_CLKS;
  localparam logic [15:0] CNT_LAST = 16'(FRAME_CLKS - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state, state_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic [ID_W-1:0]    winner;
  logic               any_valid;
  logic [NUM_REQ-1:0] ack_nxt;
  logic               start_nxt;
  logic [7:0]         data_nxt;
  logic [ID_W-1:0]    gid_nxt;
  logic               busy_nxt;

  assign any_valid = |req_valid;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Lowest pending index wins; scanning downward leaves the lowest hit last.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = ID_W'(i);
    end
  end
`else
  logic [ID_W-1:0] rr_ptr, rr_nxt;
  int              idx;

  // First pending index at or above rr_ptr, wrapping; downward scan keeps the nearest.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) winner = ID_W'(idx);
    end
  end
`endif

  // State and all registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req_ack  <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      busy     <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      req_ack  <= ack_nxt;
      tx_start <= start_nxt;
      tx_data  <= data_nxt;
      grant_id <= gid_nxt;
      busy     <= busy_nxt;
`ifndef UART_ARB_FIXED_PRIO_EN
      rr_ptr   <= rr_nxt;
`endif
    end
  end

  // Leave IDLE on any pending request; leave WAIT on the last frame clock.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (any_valid) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == CNT_LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs; ack/start are single-cycle pulses.
  always_comb begin
    ack_nxt   = '0;
    start_nxt = 1'b0;
    data_nxt  = tx_data;
    gid_nxt   = grant_id;
    busy_nxt  = busy;
    cnt_nxt   = cnt;
`ifndef UART_ARB_FIXED_PRIO_EN
    rr_nxt    = rr_ptr;
`endif
    case (state)
      ST_IDLE: begin
        if (any_valid) begin
          ack_nxt[winner] = 1'b1;
          start_nxt       = 1'b1;
          data_nxt        = req_data[8*winner +: 8];
          gid_nxt         = winner;
          busy_nxt        = 1'b1;
          cnt_nxt         = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
          rr_nxt = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
`endif
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == CNT_LAST) busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter at default parameters (4 requesters, 212-clk frame).
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int FRAME = 212;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] req_ack;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic [1:0]      grant_id;
  logic            busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } grant_t;

  grant_t exp_q[$];
  grant_t e;
  int     n_cmp = 0;
  int     n_mis = 0;
  int     cyc = 0;
  bit     drop_on_ack = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .CLKS_PER_BIT(20), .GUARD_CLKS(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one clock, sample 1 time unit later; requesters drop valid on seeing their ack.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (drop_on_ack) req_valid = req_valid & ~req_ack;
  endtask

  task automatic wait_start(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    drop_on_ack = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = base + 8'(i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    tick();
    tick();
    n_cmp++;
    if ({req_ack, tx_start, tx_data, grant_id, busy} !== 16'h0000) begin
      n_mis++;
      $display("FAIL reset_outputs: got ack=%b start=%b data=%h gid=%0d busy=%b, need all zero",
               req_ack, tx_start, tx_data, grant_id, busy);
    end
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int bcnt;
    do_reset();
    req_data[7:0] = 8'hA5;
    drop_on_ack = 1'b1;
    exp_q.push_back('{id: 2'd0, data: 8'hA5});
    req_valid = 4'b0001;
    tick();
    n_cmp++;
    if (tx_start !== 1'b1) begin
      n_mis++;
      $display("FAIL single_latency: tx_start=%b one clk after valid, need 1", tx_start);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (grant_id !== e.id || tx_data !== e.data || req_ack !== 4'b0001) begin
      n_mis++;
      $display("FAIL single_grant: gid=%0d data=%h ack=%b, need gid=%0d data=%h ack=0001",
               grant_id, tx_data, req_ack, e.id, e.data);
    end
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!busy) break;
      bcnt++;
      if (tx_data !== 8'hA5) begin
        n_cmp++;
        n_mis++;
        $display("FAIL single_hold: tx_data=%h mid-frame, need a5", tx_data);
      end
    end
    n_cmp++;
    if (bcnt != FRAME) begin
      n_mis++;
      $display("FAIL single_busy_len: busy high %0d clks, need %0d", bcnt, FRAME);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int prev;
    do_reset();
    set_data(8'h10);
    drop_on_ack = 1'b1;
    for (int k = 0; k < NREQ; k++) exp_q.push_back('{id: 2'(k), data: 8'h10 + 8'(k)});
    req_valid = 4'b1111;
    prev = 0;
    for (int k = 0; k < NREQ; k++) begin
      wait_start(400, ok);
      n_cmp++;
      if (!ok) begin
        n_mis++;
        $display("FAIL b2b_start%0d: no tx_start within 400 clks, need one", k);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (grant_id !== e.id || tx_data !== e.data || req_ack !== (4'b0001 << e.id)) begin
          n_mis++;
          $display("FAIL b2b_grant%0d: gid=%0d data=%h ack=%b, need gid=%0d data=%h",
                   k, grant_id, tx_data, req_ack, e.id, e.data);
        end
        if (k > 0) begin
          n_cmp++;
          if (cyc - prev != FRAME + 1) begin
            n_mis++;
            $display("FAIL b2b_spacing%0d: %0d clks between starts, need %0d", k, cyc - prev, FRAME + 1);
          end
        end
        prev = cyc;
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    set_data(8'h30);
    drop_on_ack = 1'b1;
    exp_q.push_back('{id: 2'd2, data: 8'h32});
    exp_q.push_back('{id: 2'd3, data: 8'h33});
    exp_q.push_back('{id: 2'd0, data: 8'h30});
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_start(400, ok);
      if (k == 0) req_valid = 4'b1001;
      n_cmp++;
      if (!ok) begin
        n_mis++;
        $display("FAIL wrap_start%0d: no tx_start within 400 clks, need one", k);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (grant_id !== e.id || tx_data !== e.data || req_ack !== (4'b0001 << e.id)) begin
          n_mis++;
          $display("FAIL wrap_grant%0d: gid=%0d data=%h ack=%b, need gid=%0d data=%h",
                   k, grant_id, tx_data, req_ack, e.id, e.data);
        end
      end
    end
  endtask

  // Runs straight after test_wrap, while its last frame is still being timed.
  task automatic test_ignore_in_wait();
    int acks;
    int starts;
    acks = 0;
    starts = 0;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req_ack[1]) acks++;
      if (tx_start) starts++;
    end
    req_valid[1] = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (req_ack[1]) acks++;
      if (tx_start) starts++;
    end
    n_cmp++;
    if (acks != 0 || starts != 0) begin
      n_mis++;
      $display("FAIL wait_ignore: ack1 pulses=%0d starts=%0d, need 0 and 0", acks, starts);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_mis++;
      $display("FAIL wait_idle: busy=%b after frame end, need 0", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    set_data(8'h50);
    drop_on_ack = 1'b1;
    exp_q.push_back('{id: 2'd1, data: 8'h51});
    req_valid = 4'b0010;
    wait_start(10, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || grant_id !== e.id || tx_data !== e.data) begin
      n_mis++;
      $display("FAIL rst_first_grant: ok=%b gid=%0d data=%h, need gid=%0d data=%h",
               ok, grant_id, tx_data, e.id, e.data);
    end
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    req_valid = 4'b0101;
    tick();
    n_cmp++;
    if ({req_ack, tx_start, tx_data, grant_id, busy} !== 16'h0000) begin
      n_mis++;
      $display("FAIL rst_mid: ack=%b start=%b data=%h gid=%0d busy=%b, need all zero",
               req_ack, tx_start, tx_data, grant_id, busy);
    end
    reset = 1'b0;
    exp_q.push_back('{id: 2'd0, data: 8'h50});
    exp_q.push_back('{id: 2'd2, data: 8'h52});
    for (int k = 0; k < 2; k++) begin
      wait_start(400, ok);
      n_cmp++;
      if (!ok) begin
        n_mis++;
        $display("FAIL rst_after_start%0d: no tx_start within 400 clks, need one", k);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (grant_id !== e.id || tx_data !== e.data || req_ack !== (4'b0001 << e.id)) begin
          n_mis++;
          $display("FAIL rst_after_grant%0d: gid=%0d data=%h ack=%b, need gid=%0d data=%h",
                   k, grant_id, tx_data, req_ack, e.id, e.data);
        end
      end
    end
  endtask

  // Requesters 0 and 2 held continuously (never dropped).
  task automatic test_held_pair();
    bit ok;
    do_reset();
    set_data(8'h60);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 3; k++) exp_q.push_back('{id: 2'd0, data: 8'h60});
`else
    exp_q.push_back('{id: 2'd0, data: 8'h60});
    exp_q.push_back('{id: 2'd2, data: 8'h62});
    exp_q.push_back('{id: 2'd0, data: 8'h60});
`endif
    req_valid = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      wait_start(400, ok);
      n_cmp++;
      if (!ok) begin
        n_mis++;
        $display("FAIL held_start%0d: no tx_start within 400 clks, need one", k);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (grant_id !== e.id || tx_data !== e.data || req_ack !== (4'b0001 << e.id)) begin
          n_mis++;
          $display("FAIL held_grant%0d: gid=%0d data=%h ack=%b, need gid=%0d data=%h",
                   k, grant_id, tx_data, req_ack, e.id, e.data);
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_ignore_in_wait();
    test_reset_mid_frame();
    test_held_pair();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: %0d expected grants left, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
